fs_accel_wload_ctrl: RTL and testbench

FS_ACCEL_WLOAD_CTRL -- requirements
Module: fs_accel_wload_ctrl

---
 rtl/fs_accel_wload_ctrl_pkg.sv | 21 ++
 rtl/fs_accel_wload_ctrl.sv | 149 ++++++++++++++
 tb/tb_fs_accel_wload_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fs_accel_wload_ctrl_pkg.sv
// Shared accelerator definitions: weight-load FSM states and 3x3 kernel geometry.
package fs_accel_wload_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_LD   = 3'd3,
    ST_HOLD = 3'd4,
    ST_FIN  = 3'd5
  } wl_state_t;

  localparam int unsigned KBYTES = 9;
  localparam int unsigned KROWS  = 3;
  localparam int unsigned KCOLS  = KBYTES / KROWS;

  function automatic logic [KROWS-1:0] row_onehot(input logic [1:0] row);
    return KROWS'(1) << row;
  endfunction

endpackage

// File: rtl/fs_accel_wload_ctrl.sv
// Weight-load controller: streams 3x3 kernels byte-by-byte from weight memory
// into three row registers and hands each complete kernel to the MAC array.
module fs_accel_wload_ctrl
  import fs_accel_wload_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int KCNT_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [KCNT_W-1:0] num_kernels,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        wreg_di_0,
  output logic [7:0]        wreg_di_1,
  output logic [7:0]        wreg_di_2,
  output logic [2:0]        wreg_enb,
  output logic              k_valid,
  input  logic              k_ready,
  output logic              busy,
  output logic              done
);

  wl_state_t         r_state;
  wl_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [KCNT_W-1:0] r_cnt;
  logic [1:0]        r_row;
  logic [1:0]        r_col;
  logic [7:0]        r_byte0;
  logic [7:0]        r_byte1;
  logic [7:0]        r_byte2;
  logic              r_rd_vld;
  logic [1:0]        r_rd_col;

  logic              w_rd_en;
  logic [2:0]        w_enb;
  logic              w_kvalid;
  logic              w_done;
  logic              w_xfer;
  logic              w_last_col;
  logic              w_last_row;

  assign w_last_col = (r_col == 2'(KCOLS - 1));
  assign w_last_row = (r_row == 2'(KROWS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_enb       = '0;
    w_kvalid    = 1'b0;
    w_done      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (num_kernels == '0) ? ST_FIN : ST_RD;
      end
      ST_RD: begin
        w_rd_en = 1'b1;
        if (w_last_col) w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        w_state_nxt = ST_LD;
      end
      ST_LD: begin
        w_enb       = row_onehot(r_row);
        w_state_nxt = w_last_row ? ST_HOLD : ST_RD;
      end
      ST_HOLD: begin
        w_kvalid = 1'b1;
        if (k_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = (r_cnt == KCNT_W'(1)) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_byte0  <= '0;
      r_byte1  <= '0;
      r_byte2  <= '0;
      r_rd_vld <= 1'b0;
      r_rd_col <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Read data lags the strobe by one cycle, so the issuing column travels with it.
      r_rd_vld <= w_rd_en;
      r_rd_col <= r_col;
      if (r_rd_vld) begin
        case (r_rd_col)
          2'd0:    r_byte0 <= mem_rdata;
          2'd1:    r_byte1 <= mem_rdata;
          default: r_byte2 <= mem_rdata;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr <= base_addr;
            r_cnt <= num_kernels;
            r_row <= '0;
            r_col <= '0;
          end
        end
        ST_RD: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          r_col <= w_last_col ? 2'd0 : r_col + 2'd1;
        end
        ST_LD: begin
          if (!w_last_row) r_row <= r_row + 2'd1;
        end
        ST_HOLD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - KCNT_W'(1);
            r_row <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_en = w_rd_en;
  assign mem_addr  = r_ptr;
  assign wreg_di_0 = r_byte0;
  assign wreg_di_1 = r_byte1;
  assign wreg_di_2 = r_byte2;
  assign wreg_enb  = w_enb;
  assign k_valid   = w_kvalid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_done;

endmodule

// File: tb/tb_fs_accel_wload_ctrl.sv
// Bench for fs_accel_wload_ctrl: memory responder, job driver and a
// transaction-level model of the expected reads, row loads and handshakes.
module tb_fs_accel_wload_ctrl;

  localparam int ADDR_W = 16;
  localparam int KCNT_W = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [KCNT_W-1:0] num_kernels;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        wreg_di_0, wreg_di_1, wreg_di_2;
  logic [2:0]        wreg_enb;
  logic              k_valid;
  logic              k_ready;
  logic              busy;
  logic              done;

  fs_accel_wload_ctrl #(.ADDR_W(ADDR_W), .KCNT_W(KCNT_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_kernels(num_kernels), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .wreg_di_0(wreg_di_0), .wreg_di_1(wreg_di_1),
    .wreg_di_2(wreg_di_2), .wreg_enb(wreg_enb), .k_valid(k_valid),
    .k_ready(k_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency, junk on the bus when not reading.
  logic [7:0] mem [0:65535];
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] base;
    int          nk;
    int          w;
    bit          noise;
    int          exp_reads;
    int          exp_loads;
    int          exp_xfers;
    int          exp_done_lat;
    int          exp_kv_lat;
  } vec_t;

  // Runs one job; every read address and row load is checked against the
  // memory image as it happens, summary figures are returned to the caller.
  task automatic run_job(input logic [15:0] base, input int nk, input int w, input bit noise,
                         output int n_reads, output int n_loads, output int n_xfers,
                         output int n_done, output int done_lat, output int kv_lat,
                         output int viol);
    int   samp;
    int   hcnt;
    int   k;
    int   r;
    bit   prev_kv;
    bit   prev_rdy;
    logic [15:0] ea;
    logic [31:0] exp_ld;
    n_reads = 0; n_loads = 0; n_xfers = 0; n_done = 0;
    done_lat = -1; kv_lat = -1; viol = 0;
    hcnt = 0; prev_kv = 0; prev_rdy = 0;
    @(negedge clk);
    base_addr   = base;
    num_kernels = KCNT_W'(nk);
    start       = 1'b1;
    k_ready     = 1'b0;
    for (samp = 1; samp <= 3000; samp++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_rd_en) begin
        ea = base + 16'(n_reads);
        chk("rd_addr", 64'(mem_addr), 64'(ea));
        n_reads++;
      end
      if (wreg_enb != 3'b000) begin
        k = n_loads / 3;
        r = n_loads % 3;
        ea = base + 16'(9 * k + 3 * r);
        exp_ld = {5'b0, 3'(1 << r), mem[ea], mem[16'(ea + 16'd1)], mem[16'(ea + 16'd2)]};
        chk("wreg_load", 64'({5'b0, wreg_enb, wreg_di_0, wreg_di_1, wreg_di_2}), 64'(exp_ld));
        n_loads++;
      end
      if (k_valid && kv_lat < 0) kv_lat = samp;
      if (prev_kv && prev_rdy) n_xfers++;
      if (mem_rd_en && wreg_enb != 3'b000) viol++;
      if (wreg_enb != 3'b000 && wreg_enb != 3'b001 && wreg_enb != 3'b010 && wreg_enb != 3'b100) viol++;
      if (prev_kv && !prev_rdy && !k_valid) viol++;
      if ((mem_rd_en || wreg_enb != 3'b000 || k_valid || done) && !busy) viol++;
      if (done) begin
        n_done++;
        done_lat = samp;
        break;
      end
      prev_kv = k_valid;
      if (k_valid) begin
        k_ready = (hcnt >= w);
        hcnt++;
      end else begin
        hcnt = 0;
        k_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_rdy = k_ready;
      if (noise && busy && $urandom_range(0, 3) == 0) begin
        start       = 1'b1;
        base_addr   = 16'($urandom);
        num_kernels = KCNT_W'($urandom);
      end
    end
    start   = 1'b0;
    k_ready = 1'b0;
    if (done_lat < 0) chk("job_timeout", 64'(1), 64'(0));
    @(negedge clk);
    chk("idle_after_done", 64'({busy, done, k_valid, mem_rd_en, wreg_enb}), 64'(0));
  endtask

  task automatic check_job(input string tag, input vec_t v);
    int n_reads, n_loads, n_xfers, n_done, done_lat, kv_lat, viol;
    run_job(v.base, v.nk, v.w, v.noise, n_reads, n_loads, n_xfers, n_done, done_lat, kv_lat, viol);
    chk({tag, "_reads"},    64'(n_reads),  64'(v.exp_reads));
    chk({tag, "_loads"},    64'(n_loads),  64'(v.exp_loads));
    chk({tag, "_xfers"},    64'(n_xfers),  64'(v.exp_xfers));
    chk({tag, "_done_cnt"}, 64'(n_done),   64'(1));
    chk({tag, "_done_lat"}, 64'(done_lat), 64'(v.exp_done_lat));
    chk({tag, "_kv_lat"},   64'(kv_lat),   64'(v.exp_kv_lat));
    chk({tag, "_protocol"}, 64'(viol),     64'(0));
  endtask

  vec_t vecs [5];
  vec_t rv;

  initial begin
    bit found;
    resetn = 1'b0; start = 1'b0; base_addr = '0; num_kernels = '0; k_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) mem[16'h0100 + i] = 8'(i + 1);

    //            base     nk w noise reads loads xfers done_lat kv_lat
    vecs[0] = '{16'h0100, 1, 0, 1'b0,  9,  3, 1, 17, 16};
    vecs[1] = '{16'h0400, 3, 5, 1'b1, 27,  9, 3, 64, 16};
    vecs[2] = '{16'h0800, 0, 0, 1'b0,  0,  0, 0,  1, -1};
    vecs[3] = '{16'hFFFC, 1, 2, 1'b0,  9,  3, 1, 19, 16};
    vecs[4] = '{16'h1234, 2, 1, 1'b1, 18,  6, 2, 35, 16};

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({mem_rd_en, mem_addr, wreg_di_0, wreg_di_1, wreg_di_2,
                            wreg_enb, k_valid, busy, done}), 64'(0));
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) check_job($sformatf("vec%0d", i), vecs[i]);

    // Reset while row 1 is being loaded, then rerun the same job.
    @(negedge clk);
    base_addr = 16'h0200; num_kernels = 8'd2; start = 1'b1;
    found = 0;
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      start = 1'b0;
      if (wreg_enb == 3'b010) begin
        found = 1;
        break;
      end
    end
    chk("mid_reset_reached_ld_row1", 64'(found), 64'(1));
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 64'({mem_rd_en, mem_addr, wreg_di_0, wreg_di_1, wreg_di_2,
                                  wreg_enb, k_valid, busy, done}), 64'(0));
    resetn = 1'b1;
    rv = '{16'h0200, 2, 0, 1'b0, 18, 6, 2, 33, 16};
    check_job("after_reset", rv);

    // Random jobs against arithmetic expectations.
    for (int j = 0; j < 20; j++) begin
      rv.base  = 16'($urandom);
      rv.nk    = $urandom_range(0, 4);
      rv.w     = $urandom_range(0, 3);
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_reads    = 9 * rv.nk;
      rv.exp_loads    = 3 * rv.nk;
      rv.exp_xfers    = rv.nk;
      rv.exp_done_lat = 1 + rv.nk * (16 + rv.w);
      rv.exp_kv_lat   = (rv.nk > 0) ? 16 : -1;
      check_job($sformatf("rand%0d", j), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
